// File: rtl/d_uncache_bridge_pkg.sv
// Shared types and constants for the uncached data-side AXI3 bridge.
package d_uncache_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned ASIZE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [ASIZE_W-1:0] SIZE_B = 3'd0;
  localparam logic [ASIZE_W-1:0] SIZE_H = 3'd1;
  localparam logic [ASIZE_W-1:0] SIZE_W = 3'd2;

  // Every uncached access is a single beat.
  localparam logic [LEN_W-1:0] BURST_LEN = 4'd0;

endpackage

// File: rtl/d_uncache_bridge.sv
// Single-beat uncached load/store bridge from the memory stage to an AXI3 master port.
module d_uncache_bridge
  import d_uncache_bridge_pkg::*;
#(
  parameter logic [ID_W-1:0] RD_ID = 4'd1,
  parameter logic [ID_W-1:0] WR_ID = 4'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_en,
  input  logic [STRB_W-1:0]   data_wen,
  input  logic [ADDR_W-1:0]   data_paddr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic                no_cache,
  input  logic                pipe_stall,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_stall,
  output logic [ID_W-1:0]     arid,
  output logic [LEN_W-1:0]    arlen,
  output logic [ASIZE_W-1:0]  arsize,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_W-1:0]     awid,
  output logic [LEN_W-1:0]    awlen,
  output logic [ASIZE_W-1:0]  awsize,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [STRB_W-1:0]   wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  state_e              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          size_q;
  logic [STRB_W-1:0]   wen_q;
  logic                aw_done;
  logic                w_done;
  logic                req;
  logic                aw_hs;
  logic                w_hs;

  // Response IDs/status are not checked; errors are silently dropped.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

  assign req   = data_en & no_cache;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // Combinational so the request cycle itself stalls the pipeline.
  assign data_stall = ((state == ST_IDLE) & req) | (state == ST_RD) | (state == ST_WR);

  assign arid   = RD_ID;
  assign arlen  = BURST_LEN;
  assign arsize = {1'b0, size_q};
  assign araddr = addr_q;

  assign awid   = WR_ID;
  assign awlen  = BURST_LEN;
  assign awsize = {1'b0, size_q};
  assign awaddr = addr_q;

  assign wid    = WR_ID;
  assign wdata  = wdata_q;
  assign wstrb  = wen_q;
  assign wlast  = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      wen_q      <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      data_rdata <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= data_paddr;
            wdata_q <= data_wdata;
            size_q  <= data_size;
            wen_q   <= data_wen;
            if (data_wen == '0) begin
              state   <= ST_RD;
              arvalid <= 1'b1;
            end else begin
              state   <= ST_WR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end
          end
        end

        ST_RD: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
          if (rready && rvalid) begin
            data_rdata <= rdata;
            rready     <= 1'b0;
            state      <= ST_DONE;
          end
        end

        // AW and W retire independently; B is accepted only after both.
        ST_WR: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done | aw_hs) && (w_done | w_hs) && !bready) begin
            bready <= 1'b1;
          end
          if (bready && bvalid) begin
            bready  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (!pipe_stall) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_uncache_bridge.sv
// Directed self-checking bench for d_uncache_bridge with a hand-timed AXI slave.
module tb_d_uncache_bridge;
  import d_uncache_bridge_pkg::*;

  logic        clk;
  logic        rst;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_paddr;
  logic [1:0]  data_size;
  logic [31:0] data_wdata;
  logic        no_cache;
  logic        pipe_stall;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic [3:0]  arid;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks = 0;
  int errors = 0;

  d_uncache_bridge dut (
    .clk(clk), .rst(rst),
    .data_en(data_en), .data_wen(data_wen), .data_paddr(data_paddr),
    .data_size(data_size), .data_wdata(data_wdata), .no_cache(no_cache),
    .pipe_stall(pipe_stall), .data_rdata(data_rdata), .data_stall(data_stall),
    .arid(arid), .arlen(arlen), .arsize(arsize), .araddr(araddr),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awlen(awlen), .awsize(awsize), .awaddr(awaddr),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset.arvalid got %0b exp 0", arvalid); end
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL reset.awvalid got %0b exp 0", awvalid); end
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset.wvalid got %0b exp 0", wvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset.rready got %0b exp 0", rready); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL reset.bready got %0b exp 0", bready); end
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL reset.data_rdata got %h exp 0", data_rdata); end
    checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL reset.data_stall got %0b exp 0", data_stall); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset.state got %0d exp IDLE", dut.state); end
  endtask

  task automatic test_load();
    tick();
    data_en = 1'b1; no_cache = 1'b1; data_wen = 4'b0000;
    data_paddr = 32'h1FAF_F000; data_size = 2'd2;
    @(negedge clk);
    checks++; if (data_stall !== 1'b1) begin errors++; $display("FAIL load.req_stall got %0b exp 1", data_stall); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL load.req_arvalid got %0b exp 0", arvalid); end
    tick();
    @(negedge clk);
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL load.arvalid1 got %0b exp 1", arvalid); end
    checks++; if (araddr !== 32'h1FAF_F000) begin errors++; $display("FAIL load.araddr got %h exp 1faff000", araddr); end
    checks++; if (arsize !== SIZE_W) begin errors++; $display("FAIL load.arsize got %0d exp 2", arsize); end
    checks++; if (arlen !== 4'd0) begin errors++; $display("FAIL load.arlen got %0d exp 0", arlen); end
    checks++; if (arid !== 4'd1) begin errors++; $display("FAIL load.arid got %0d exp 1", arid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL load.rready_early got %0b exp 0", rready); end
    checks++; if (data_stall !== 1'b1) begin errors++; $display("FAIL load.rd_stall got %0b exp 1", data_stall); end
    tick();
    arready = 1'b1;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL load.arvalid2 got %0b exp 1", arvalid); end
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL load.arvalid_drop got %0b exp 0", arvalid); end
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL load.rready got %0b exp 1", rready); end
    checks++; if (data_stall !== 1'b1) begin errors++; $display("FAIL load.r_stall got %0b exp 1", data_stall); end
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    @(negedge clk);
    checks++; if (dut.state !== ST_DONE) begin errors++; $display("FAIL load.done_state got %0d exp DONE", dut.state); end
    checks++; if (data_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load.rdata got %h exp deadbeef", data_rdata); end
    checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL load.done_stall got %0b exp 0", data_stall); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL load.rready_drop got %0b exp 0", rready); end
    tick();
    data_en = 1'b0;
    @(negedge clk);
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL load.idle_state got %0d exp IDLE", dut.state); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL load.idle_arvalid got %0b exp 0", arvalid); end
    checks++; if (data_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load.idle_rdata got %h exp deadbeef", data_rdata); end
  endtask

  // One store; aw_at/w_at are the WR-cycle indices at which awready/wready pulse.
  task automatic write_txn(input string tag, input int aw_at, input int w_at,
                           input logic [31:0] a, input logic [3:0] wen,
                           input logic [1:0] sz, input logic [31:0] wd);
    int last;
    last = (aw_at > w_at) ? aw_at : w_at;
    tick();
    data_en = 1'b1; no_cache = 1'b1; data_wen = wen;
    data_paddr = a; data_size = sz; data_wdata = wd;
    @(negedge clk);
    checks++; if (data_stall !== 1'b1) begin errors++; $display("FAIL %s.req_stall got %0b exp 1", tag, data_stall); end
    for (int c = 0; c <= last + 1; c++) begin
      tick();
      awready = 1'(c == aw_at);
      wready  = 1'(c == w_at);
      bvalid  = 1'(c == last + 1);
      @(negedge clk);
      checks++; if (awvalid !== 1'(c <= aw_at)) begin errors++; $display("FAIL %s.awvalid c%0d got %0b exp %0b", tag, c, awvalid, c <= aw_at); end
      checks++; if (wvalid !== 1'(c <= w_at)) begin errors++; $display("FAIL %s.wvalid c%0d got %0b exp %0b", tag, c, wvalid, c <= w_at); end
      checks++; if (bready !== 1'(c == last + 1)) begin errors++; $display("FAIL %s.bready c%0d got %0b exp %0b", tag, c, bready, c == last + 1); end
      checks++; if (data_stall !== 1'b1) begin errors++; $display("FAIL %s.stall c%0d got %0b exp 1", tag, c, data_stall); end
      if (c == 0) begin
        checks++; if (awaddr !== a) begin errors++; $display("FAIL %s.awaddr got %h exp %h", tag, awaddr, a); end
        checks++; if (awsize !== {1'b0, sz}) begin errors++; $display("FAIL %s.awsize got %0d exp %0d", tag, awsize, sz); end
        checks++; if (awlen !== 4'd0) begin errors++; $display("FAIL %s.awlen got %0d exp 0", tag, awlen); end
        checks++; if (awid !== 4'd1) begin errors++; $display("FAIL %s.awid got %0d exp 1", tag, awid); end
        checks++; if (wid !== 4'd1) begin errors++; $display("FAIL %s.wid got %0d exp 1", tag, wid); end
        checks++; if (wstrb !== wen) begin errors++; $display("FAIL %s.wstrb got %b exp %b", tag, wstrb, wen); end
        checks++; if (wlast !== 1'b1) begin errors++; $display("FAIL %s.wlast got %0b exp 1", tag, wlast); end
        checks++; if (wdata !== wd) begin errors++; $display("FAIL %s.wdata got %h exp %h", tag, wdata, wd); end
      end
    end
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    @(negedge clk);
    checks++; if (dut.state !== ST_DONE) begin errors++; $display("FAIL %s.done_state got %0d exp DONE", tag, dut.state); end
    checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL %s.done_stall got %0b exp 0", tag, data_stall); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL %s.bready_drop got %0b exp 0", tag, bready); end
    tick();
    data_en = 1'b0; data_wen = 4'b0000;
    @(negedge clk);
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL %s.idle_state got %0d exp IDLE", tag, dut.state); end
    checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL %s.idle_valids got aw%0b w%0b exp 0", tag, awvalid, wvalid); end
  endtask

  task automatic test_byte_store();
    write_txn("byte_store", 0, 0, 32'h1FAF_F003, 4'b1000, 2'(SIZE_B), 32'hAB00_0000);
  endtask

  task automatic test_skewed_write();
    write_txn("skew_w_first", 3, 0, 32'h1FC0_0010, 4'b1111, 2'(SIZE_W), 32'h0BAD_F00D);
    write_txn("skew_aw_first", 1, 4, 32'h1FC0_0022, 4'b1100, 2'(SIZE_H), 32'h5A5A_0000);
  endtask

  task automatic test_back_to_back_same_cycle();
    write_txn("same_cycle", 2, 2, 32'h1FC0_0104, 4'b0011, 2'(SIZE_H), 32'h0000_CAFE);
  endtask

  task automatic test_cached();
    tick();
    data_en = 1'b1; no_cache = 1'b0; data_wen = 4'b0000; data_paddr = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) data_wen = 4'b1111;
      @(negedge clk);
      checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL cached.stall i%0d got %0b exp 0", i, data_stall); end
      checks++; if (arvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL cached.valids i%0d got ar%0b aw%0b w%0b exp 0", i, arvalid, awvalid, wvalid); end
      tick();
    end
    data_en = 1'b0; data_wen = 4'b0000;
  endtask

  task automatic test_pipe_stall_done();
    tick();
    data_en = 1'b1; no_cache = 1'b1; data_wen = 4'b0000;
    data_paddr = 32'h1000_0040; data_size = 2'd2;
    tick();
    arready = 1'b1;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL pstall.arvalid got %0b exp 1", arvalid); end
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL pstall.rready got %0b exp 1", rready); end
    tick();
    rvalid = 1'b0; rdata = 32'h0; pipe_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      checks++; if (dut.state !== ST_DONE) begin errors++; $display("FAIL pstall.state i%0d got %0d exp DONE", i, dut.state); end
      checks++; if (data_rdata !== 32'h1234_5678) begin errors++; $display("FAIL pstall.rdata i%0d got %h exp 12345678", i, data_rdata); end
      checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL pstall.arvalid i%0d got %0b exp 0", i, arvalid); end
      checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL pstall.stall i%0d got %0b exp 0", i, data_stall); end
    end
    tick();
    pipe_stall = 1'b0;
    @(negedge clk);
    checks++; if (dut.state !== ST_DONE) begin errors++; $display("FAIL pstall.release_state got %0d exp DONE", dut.state); end
    tick();
    data_en = 1'b0;
    @(negedge clk);
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL pstall.idle_state got %0d exp IDLE", dut.state); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL pstall.idle_arvalid got %0b exp 0", arvalid); end
  endtask

  task automatic test_reset_mid_read();
    tick();
    data_en = 1'b1; no_cache = 1'b1; data_wen = 4'b0000;
    data_paddr = 32'h1FAF_F100; data_size = 2'd2;
    tick();
    @(negedge clk);
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rst_mid.arvalid_pre got %0b exp 1", arvalid); end
    tick();
    rst = 1'b1; data_en = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_mid.arvalid got %0b exp 0", arvalid); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL rst_mid.state got %0d exp IDLE", dut.state); end
    checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL rst_mid.stall got %0b exp 0", data_stall); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rst_mid.rready got %0b exp 0", rready); end
  endtask

  initial begin
    rst = 1'b1; data_en = 1'b0; data_wen = 4'b0000; data_paddr = 32'h0;
    data_size = 2'd0; data_wdata = 32'h0; no_cache = 1'b0; pipe_stall = 1'b0;
    arready = 1'b0; rid = 4'd1; rdata = 32'h0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'd0; bvalid = 1'b0;

    test_reset();
    test_load();
    test_byte_store();
    test_skewed_write();
    test_back_to_back_same_cycle();
    test_cached();
    test_pipe_stall_done();
    test_reset_mid_read();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
